stoch_decode: RTL and testbench

STOCH_DECODE -- requirements
Module: stoch_decode

---
 rtl/stoch_decode.sv | 113 +++++++++++
 tb/tb_stoch_decode.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stoch_decode.sv
// Unary stochastic stream to binary decoder over a 2^DATAWD-bit window.
// Define STOCH_DECODE_BIPOLAR_EN for a two's-complement (offset) result.
module stoch_decode #(
  parameter int DATAWD = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iStart,
  input  logic              iValid,
  input  logic              iBit,
  input  logic              iReady,
  output logic [DATAWD-1:0] oData,
  output logic              oValid,
  output logic              oBusy,
  output logic              oOvf
);

  typedef enum logic {
    IDLE,
    ACC
  } state_t;

  localparam logic [DATAWD-1:0] CNT_MAX = '1;
  localparam logic [DATAWD-1:0] CNT_ONE = {{(DATAWD-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [DATAWD-1:0] cnt_q, cnt_d;
  logic [DATAWD:0]   acc_q, acc_d;
  logic [DATAWD-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;

  logic              done;
  logic [DATAWD:0]   acc_fin;
  logic [DATAWD-1:0] sat;
  logic [DATAWD-1:0] res;
  logic [DATAWD-1:0] cnt_first;
  logic [DATAWD:0]   acc_first;

  always_comb begin
    done      = (state_q == ACC) && iValid && (cnt_q == CNT_MAX);
    acc_fin   = acc_q + {{DATAWD{1'b0}}, iBit};
    sat       = acc_fin[DATAWD] ? CNT_MAX : acc_fin[DATAWD-1:0];
`ifdef STOCH_DECODE_BIPOLAR_EN
    res       = {~sat[DATAWD-1], sat[DATAWD-2:0]};
`else
    res       = sat;
`endif
    // the starting cycle's bit counts as bit 0 of the window
    cnt_first = {{(DATAWD-1){1'b0}}, iValid};
    acc_first = {{DATAWD{1'b0}}, iValid & iBit};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (valid_q && iReady) valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (iStart) begin
          state_d = ACC;
          cnt_d   = cnt_first;
          acc_d   = acc_first;
        end
      end
      ACC: begin
        if (done) begin
          data_d  = res;
          valid_d = 1'b1;
          if (valid_q && !iReady) ovf_d = 1'b1;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = iStart ? ACC : IDLE;
        end else if (iStart) begin
          cnt_d = cnt_first;
          acc_d = acc_first;
        end else if (iValid) begin
          cnt_d = cnt_q + CNT_ONE;
          acc_d = acc_fin;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oBusy  = (state_q == ACC);
  assign oOvf   = ovf_q;

endmodule

// File: tb/tb_stoch_decode.sv
// Self-checking bench for stoch_decode (DATAWD=4, 16-bit window).
// Directed scenarios plus randomized traffic against a window-count model.
module tb_stoch_decode;

  localparam int W   = 4;
  localparam int WIN = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         iStart = 1'b0;
  logic         iValid = 1'b0;
  logic         iBit = 1'b0;
  logic         iReady = 1'b0;
  logic [W-1:0] oData;
  logic         oValid;
  logic         oBusy;
  logic         oOvf;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_busy;
  int m_n;
  int m_ones;
  int m_data;
  bit m_valid;
  bit m_ovf;

  int busy_cnt;
  int pulses;

  logic [15:0] pat;

  always #5 clk = ~clk;

  stoch_decode #(.DATAWD(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .iStart(iStart),
    .iValid(iValid),
    .iBit  (iBit),
    .iReady(iReady),
    .oData (oData),
    .oValid(oValid),
    .oBusy (oBusy),
    .oOvf  (oOvf)
  );

  function automatic int enc(int v);
`ifdef STOCH_DECODE_BIPOLAR_EN
    return v - 8 < 0 ? v + 8 : v - 8;
`else
    return v;
`endif
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_busy  = 0;
    m_n     = 0;
    m_ones  = 0;
    m_data  = 0;
    m_valid = 0;
    m_ovf   = 0;
  endtask

  task automatic model_edge(bit s, bit v, bit b, bit r);
    int tot;
    if (m_busy && v && m_n == WIN - 1) begin
      tot = m_ones + int'(b);
      if (tot > WIN - 1) tot = WIN - 1;
      if (m_valid && !r) m_ovf = 1;
      m_data  = enc(tot);
      m_valid = 1;
      m_n     = 0;
      m_ones  = 0;
      m_busy  = s;
    end else begin
      if (m_valid && r) m_valid = 0;
      if (s) begin
        m_busy = 1;
        m_n    = int'(v);
        m_ones = int'(v && b);
      end else if (m_busy && v) begin
        m_n++;
        m_ones += int'(b);
      end
    end
  endtask

  task automatic step(bit s, bit v, bit b, bit r);
    iStart = s;
    iValid = v;
    iBit   = b;
    iReady = r;
    @(posedge clk);
    model_edge(s, v, b, r);
    #1;
    chk("data", 32'(oData), 32'(m_data));
    chk("valid", 32'(oValid), 32'(m_valid));
    chk("busy", 32'(oBusy), 32'(m_busy));
    chk("ovf", 32'(oOvf), 32'(m_ovf));
    if (oBusy) busy_cnt++;
    if (oValid) pulses++;
  endtask

  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_data", 32'(oData), 32'd0);
    chk("rst_valid", 32'(oValid), 32'd0);
    chk("rst_busy", 32'(oBusy), 32'd0);
    chk("rst_ovf", 32'(oOvf), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_clear();
    #1;
    chk("init_data", 32'(oData), 32'd0);
    chk("init_valid", 32'(oValid), 32'd0);
    chk("init_busy", 32'(oBusy), 32'd0);
    chk("init_ovf", 32'(oOvf), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 16 bits, 5 ones, consumer ready
    busy_cnt = 0;
    pulses   = 0;
    step(1, 0, 0, 1);
    pat = 16'h1213;
    for (int i = 0; i < WIN; i++) step(0, 1, pat[i], 1);
    chk("w5_data", 32'(oData), 32'(enc(5)));
    chk("w5_valid", 32'(oValid), 32'd1);
    chk("w5_busy_cycles", 32'(busy_cnt), 32'd16);
    step(0, 0, 0, 1);
    chk("w5_pulse", 32'(pulses), 32'd1);

    // all ones saturates
    step(1, 0, 0, 1);
    for (int i = 0; i < WIN; i++) step(0, 1, 1, 1);
    chk("sat_data", 32'(oData), 32'(enc(15)));

    // 8 ones with 10 idle cycles interleaved
    step(1, 0, 0, 1);
    pat = 16'hAAAA;
    for (int i = 0; i < WIN; i++) begin
      if (i < 10) step(0, 0, 1'($urandom), 1);
      step(0, 1, pat[i], 1);
    end
    chk("gap_data", 32'(oData), 32'(enc(8)));
    step(0, 0, 0, 1);

    // back-to-back windows, consumer stalled
    do_reset();
    step(1, 0, 0, 0);
    pat = 16'h0007;
    for (int i = 0; i < WIN - 1; i++) step(0, 1, pat[i], 0);
    step(1, 1, pat[WIN-1], 0);
    chk("b2b_first", 32'(oData), 32'(enc(3)));
    pat = 16'h01FF;
    for (int i = 0; i < WIN; i++) step(0, 1, pat[i], 0);
    chk("b2b_data", 32'(oData), 32'(enc(9)));
    chk("b2b_valid", 32'(oValid), 32'd1);
    chk("b2b_ovf", 32'(oOvf), 32'd1);

    // abort after 7 bits, then a full window with 2 ones
    do_reset();
    pulses = 0;
    step(1, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    pat = 16'h8001;
    for (int i = 0; i < WIN; i++) step(0, 1, pat[i], 1);
    chk("abort_data", 32'(oData), 32'(enc(2)));
    step(0, 0, 0, 1);
    chk("abort_results", 32'(pulses), 32'd1);

    // reset in the middle of a window
    pulses = 0;
    step(1, 1, 1, 1);
    for (int i = 0; i < 9; i++) step(0, 1, 1, 1);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 1, 1, 1);
    chk("midrst_results", 32'(pulses), 32'd0);
    chk("midrst_busy", 32'(oBusy), 32'd0);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
           1'($urandom), $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
